array_slice_writer: RTL
=======================

// Module: array_slice_writer
// PURPOSE
// - Write-side companion to our combinational array readers. Owns a DEPTH x WIDTH register
//   array and updates a bit-slice [lsb +: len] of one entry per request, using read-modify-write.
// - Bits of the entry outside the slice are preserved.
// - Exposes a combinational slice read port so downstream logic and tests can index
//   mem[idx] >> lsb.
// - Sits between a request producer (valid/ready) and array consumers.
// PARAMETERS
// - DEPTH  4                  number of array entries
// - WIDTH  8                  bits per entry
// - IDX_W  $clog2(DEPTH)+1    index width; the extra bit lets out-of-range indices be expressed
// - LSB_W  $clog2(WIDTH)      slice start-bit width
// - LEN_W  $clog2(WIDTH)+1    slice length width (range 0..WIDTH)
// PORTS
// - clk       in   1      single clock; all state updates on posedge
// - rst       in   1      synchronous, active-high reset
// - wr_valid  in   1      request valid
// - wr_ready  out  1      block can accept a request
// - wr_idx    in   IDX_W  target entry
// - wr_lsb    in   LSB_W  slice start bit
// - wr_len    in   LEN_W  slice length in bits
// - wr_data   in   WIDTH  slice value, right-aligned; bits >= wr_len ignored
// - done      out  1      one-cycle pulse, request retired
// - err       out  1      valid only with done; request was malformed
// - rd_idx    in   IDX_W  read entry index
// - rd_lsb    in   LSB_W  read slice start
// - rd_slice  out  WIDTH  mem[rd_idx] >> rd_lsb; 0 if rd_idx >= DEPTH
// BEHAVIOUR
// - Reset: all mem entries = 0; FSM = IDLE; wr_ready = 1; done = 0; err = 0.
//   Reset has priority over every other event.
// - FSM states and transitions:
//   - IDLE: wr_ready = 1. On wr_valid & wr_ready, latch idx/lsb/len/data and go to READ.
//   - READ: register old = mem[idx], or 0 if idx is out of range. Go to WRITE.
//   - WRITE: mask = ((1<<len)-1) << lsb, truncated to WIDTH.
//     If the request is writable, mem[idx] <= (old & ~mask) | ((data << lsb) & mask).
//     Go to RESP.
//   - RESP: done = 1 and err = latched error. Go to IDLE.
// - Timing: accept at edge T; memory updated at edge closing cycle T+2; done high in
//   cycle T+3; wr_ready high again in T+4.
// - Throughput: one request per 4 cycles.
// - wr_ready is low in READ, WRITE and RESP. Requests presented then are not accepted and
//   must be held by the producer.
// - Errors, all recorded as err = 1:
//   - idx >= DEPTH: no entry changes.
//   - len == 0: no entry changes.
//   - lsb + len > WIDTH: the in-range bits are still written; bits above WIDTH-1 are dropped.
// - Arithmetic:
//   - Compute the shift and mask in WIDTH+LEN_W bits, then truncate to WIDTH.
//   - len == WIDTH gives a full-entry mask.
// - Read port:
//   - Purely combinational.
//   - A read of the entry being written returns the old value through cycle T+2 and the new
//     value from T+3.
// - Reset during READ or WRITE: the request is dropped, there is no done pulse, and memory
//   is cleared. The FSM is in IDLE with wr_ready = 1 on the cycle after reset deasserts.
// - wr_valid during reset is ignored.
// STRUCTURE
// - Shared package array_pkg holds:
//   - the FSM state enum (IDLE, READ, WRITE, RESP);
//   - function slice_mask(lsb, len);
//   - localparams derived from WIDTH/DEPTH.
// - Sub-module slice_merge: combinational (old, data, lsb, len) -> (merged, ovf).
//   Reused by future array writers.
// - Top level: request latch, FSM, mem array, read mux.
// TESTING
// - Defaults DEPTH=4, WIDTH=8.
// 1. Reset, then sweep rd_idx 0..3 with rd_lsb=0.
//    -> rd_slice=8'h00; wr_ready=1, done=0.
// 2. idx=2 lsb=1 len=2 data=8'h03 on a zero entry.
//    -> mem[2]=8'h06; done at T+3, err=0; rd_idx=2, rd_lsb=1 -> 8'h03.
// 3. Preload mem[1]=8'hFF, then idx=1 lsb=4 len=3 data=8'h00.
//    -> mem[1]=8'h8F, err=0.
// 4. idx=0 lsb=6 len=4 data=8'h0F.
//    -> mem[0]=8'hC0, err=1.
//    Separately, idx=5 -> err=1 with all entries unchanged.
//    Separately, len=0 -> err=1 with no change.
// 5. Two requests back-to-back, wr_valid held.
//    -> wr_ready low for 3 cycles; second accepted at T+4; both done pulses occur,
//       4 cycles apart.
// 6. rst asserted in the WRITE cycle of a request to idx=3.
//    -> no done, all entries 0, wr_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/array_pkg.sv
// Shared definitions for the array writer/reader family.
//   state_t    : writer FSM states
//   slice_mask : bit mask covering [lsb +: len], computed wide so that
//                lsb + len may run past the entry width without wrapping
//   DEF_*      : default geometry and the widths derived from it
package array_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_IDX_W = $clog2(DEF_DEPTH) + 1;
  localparam int DEF_LSB_W = $clog2(DEF_WIDTH);
  localparam int DEF_LEN_W = $clog2(DEF_WIDTH) + 1;

  // Widest entry any writer may use; callers truncate to their WIDTH.
  localparam int MASK_W = 64;

  // Bitwise construction instead of ((1<<len)-1)<<lsb: same result, and no
  // dependence on the shift width when len == WIDTH or lsb + len > WIDTH.
  function automatic logic [MASK_W-1:0] slice_mask(input int unsigned lsb,
                                                   input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++)
      if (i >= lsb && i < lsb + len) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/array_slice_writer_if.sv
// Request/response and read-port bundle of array_slice_writer.
//   master : request producer / reader (drives wr_*, rd_idx, rd_lsb)
//   slave  : the writer block (drives wr_ready, done, err, rd_slice)
interface array_slice_writer_if
  import array_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = $clog2(DEPTH) + 1,
  parameter int LSB_W = $clog2(WIDTH),
  parameter int LEN_W = $clog2(WIDTH) + 1
);
  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_idx;
  logic [LSB_W-1:0] wr_lsb;
  logic [LEN_W-1:0] wr_len;
  logic [WIDTH-1:0] wr_data;
  logic             done;
  logic             err;
  logic [IDX_W-1:0] rd_idx;
  logic [LSB_W-1:0] rd_lsb;
  logic [WIDTH-1:0] rd_slice;

  modport master (
    output wr_valid, wr_idx, wr_lsb, wr_len, wr_data, rd_idx, rd_lsb,
    input  wr_ready, done, err, rd_slice
  );

  modport slave (
    input  wr_valid, wr_idx, wr_lsb, wr_len, wr_data, rd_idx, rd_lsb,
    output wr_ready, done, err, rd_slice
  );
endinterface

// File: rtl/array_slice_writer_slice_merge.sv
// slice_merge: combinational read-modify-write merge of one slice.
//   old    : current entry value
//   data   : right-aligned slice value (bits >= len ignored)
//   lsb    : slice start bit
//   len    : slice length, 0..WIDTH
//   merged : old with [lsb +: len] replaced, bits above WIDTH-1 dropped
//   ovf    : lsb + len exceeds WIDTH
module slice_merge
  import array_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LSB_W = $clog2(WIDTH),
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] old,
  input  logic [LSB_W-1:0] lsb,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] merged,
  output logic             ovf
);
  logic [MASK_W-1:0] mask_full;
  logic [WIDTH-1:0]  mask;
  logic [LEN_W:0]    span;

  assign mask_full = slice_mask(32'(lsb), 32'(len));
  assign mask      = mask_full[WIDTH-1:0];

  // Shifted data is truncated to WIDTH, which drops the out-of-range bits.
  assign merged = (old & ~mask) | ((data << lsb) & mask);

  // One extra bit so lsb + len cannot wrap before the compare.
  assign span = (LEN_W+1)'(lsb) + (LEN_W+1)'(len);
  assign ovf  = span > (LEN_W+1)'(WIDTH);
endmodule

// File: rtl/array_slice_writer.sv
// array_slice_writer: DEPTH x WIDTH register array updated one bit-slice
// per request by read-modify-write (IDLE -> READ -> WRITE -> RESP).
//   clk, rst   : clock, synchronous active-high reset
//   bus.wr_*   : request (valid/ready), idx/lsb/len/data
//   bus.done   : one-cycle retire pulse; bus.err qualifies it
//   bus.rd_*   : combinational read, rd_slice = mem[rd_idx] >> rd_lsb
module array_slice_writer
  import array_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = $clog2(DEPTH) + 1,
  parameter int LSB_W = $clog2(WIDTH),
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input logic                 clk,
  input logic                 rst,
  array_slice_writer_if.slave bus
);
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [LSB_W-1:0] lsb;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] data;
  } req_t;

  state_t                      state_q, state_d;
  req_t                        req_q;
  logic [WIDTH-1:0]            old_q;
  logic                        err_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0]            wr_en;
  logic [WIDTH-1:0]            old_sel, rd_sel, merged;
  logic                        ovf, in_range, writable, accept;

  assign in_range = req_q.idx < IDX_W'(DEPTH);
  assign writable = in_range && (req_q.len != '0);
  assign accept   = (state_q == IDLE) && bus.wr_valid;

  slice_merge #(.WIDTH(WIDTH), .LSB_W(LSB_W), .LEN_W(LEN_W)) u_merge (
    .old    (old_q),
    .lsb    (req_q.lsb),
    .len    (req_q.len),
    .data   (req_q.data),
    .merged (merged),
    .ovf    (ovf)
  );

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.wr_ready = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.wr_ready = 1'b1;
        if (bus.wr_valid) state_d = READ;
      end
      READ:  state_d = WRITE;
      WRITE: state_d = RESP;
      RESP: begin
        bus.done = 1'b1;
        bus.err  = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry mux for the RMW read; out-of-range idx yields zero.
  always_comb begin
    old_sel = '0;
    for (int e = 0; e < DEPTH; e++)
      if (req_q.idx == IDX_W'(e)) old_sel = mem_q[e];
  end

  // Request latch, old-value register, error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
      old_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept)
        req_q <= '{idx: bus.wr_idx, lsb: bus.wr_lsb, len: bus.wr_len, data: bus.wr_data};
      if (state_q == READ)  old_q <= old_sel;
      // An overflowing slice is still written; it is only flagged.
      if (state_q == WRITE) err_q <= !writable || ovf;
    end
  end

  // Per-entry write enables
  for (genvar e = 0; e < DEPTH; e++) begin : g_wen
    assign wr_en[e] = (state_q == WRITE) && writable && (req_q.idx == IDX_W'(e));
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else
      for (int e = 0; e < DEPTH; e++)
        if (wr_en[e]) mem_q[e] <= merged;
  end

  // Combinational read port
  always_comb begin
    rd_sel = '0;
    for (int e = 0; e < DEPTH; e++)
      if (bus.rd_idx == IDX_W'(e)) rd_sel = mem_q[e];
  end

  assign bus.rd_slice = rd_sel >> bus.rd_lsb;
endmodule
